// File: rtl/bin_neuron_pkg.sv
// Shared defaults and arithmetic helpers for the binarised neuron array.
package bin_neuron_pkg;

  localparam int IN_W_DEF  = 64;
  localparam int CH_DEF    = 8;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 16;

  // Popcount of an XNOR word mapped onto the bipolar {-1,+1} domain.
  function automatic int bipolar(input int pop, input int width);
    return 2 * pop - width;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint hi;
    longint lo;
    longint s;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/bin_neuron_array_popcount_tree.sv
// Combinational population count of an IN_W-bit word.
module popcount_tree #(
  parameter int IN_W = 64
) (
  input  logic [IN_W-1:0]            bits,
  output logic [$clog2(IN_W+1)-1:0]  count
);

  localparam int PC_W = $clog2(IN_W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < IN_W; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/bin_neuron_array.sv
// Multi-channel XNOR-popcount neuron array with valid/ready handshake.
// Optional per-channel final-sum output enabled by NEURON_ARRAY_SUM_OUT_EN.
module bin_neuron_array
  import bin_neuron_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int CH    = CH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [IN_W-1:0]         act_in,
  input  logic [CH*IN_W-1:0]      wgt_in,
  input  logic [LEN_W-1:0]        in_length,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    thr_wr_en,
  input  logic [$clog2(CH)-1:0]   thr_wr_ch,
  input  logic [ACC_W-1:0]        thr_wr_data,
  output logic [CH-1:0]           out_bits,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef NEURON_ARRAY_SUM_OUT_EN
  ,
  output logic [CH*ACC_W-1:0]     out_sum
`endif
);

  localparam int PC_W = $clog2(IN_W + 1);

  logic                    stall;
  logic                    rdy_q;
  logic                    accept;
  logic [LEN_W-1:0]        cnt_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_eff;
  logic                    last_beat;

  logic                    s1_valid, s1_last;
  logic [IN_W-1:0]         s1_xnor [CH];
  logic [PC_W-1:0]         pop_w   [CH];
  logic                    s2_valid, s2_last;
  logic [PC_W-1:0]         s2_pop  [CH];

  logic signed [ACC_W-1:0] acc_q   [CH];
  logic signed [ACC_W-1:0] acc_sum [CH];
  logic signed [ACC_W-1:0] thr_q   [CH];
  logic [CH-1:0]           hit;

  // rdy_q keeps in_ready low while reset is held.
  assign stall    = out_valid && !out_ready;
  assign in_ready = rdy_q && !stall;
  assign accept   = in_valid && in_ready;

  // Length is captured on the first beat; a zero length behaves as one.
  always_comb begin
    len_eff = len_q;
    if (cnt_q == '0) len_eff = (in_length == '0) ? LEN_W'(1) : in_length;
    last_beat = ({1'b0, cnt_q} + (LEN_W+1)'(1)) >= {1'b0, len_eff};
  end

  for (genvar c = 0; c < CH; c++) begin : g_pop
    popcount_tree #(.IN_W(IN_W)) u_pop (
      .bits  (s1_xnor[c]),
      .count (pop_w[c])
    );
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      acc_sum[c] = ACC_W'(sat_add(longint'(acc_q[c]),
                                  longint'(bipolar(int'(s2_pop[c]), IN_W)),
                                  ACC_W));
      hit[c]     = (acc_sum[c] >= thr_q[c]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < CH; c++) thr_q[c] <= '0;
    end else if (thr_wr_en) begin
      thr_q[thr_wr_ch] <= $signed(thr_wr_data);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_bits  <= '0;
`ifdef NEURON_ARRAY_SUM_OUT_EN
      out_sum   <= '0;
`endif
      for (int c = 0; c < CH; c++) begin
        s1_xnor[c] <= '0;
        s2_pop[c]  <= '0;
        acc_q[c]   <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (!stall) begin
        if (accept) begin
          cnt_q <= last_beat ? '0 : cnt_q + LEN_W'(1);
          if (cnt_q == '0) len_q <= len_eff;
        end
        s1_valid <= accept;
        s1_last  <= accept && last_beat;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        for (int c = 0; c < CH; c++) begin
          if (accept)   s1_xnor[c] <= ~(act_in ^ wgt_in[c*IN_W +: IN_W]);
          if (s1_valid) s2_pop[c]  <= pop_w[c];
          if (s2_valid) acc_q[c]   <= s2_last ? '0 : acc_sum[c];
        end
        // A new result may replace the one handed off on this same edge.
        if (s2_valid && s2_last) begin
          out_valid <= 1'b1;
          out_bits  <= hit;
`ifdef NEURON_ARRAY_SUM_OUT_EN
          for (int c = 0; c < CH; c++) out_sum[c*ACC_W +: ACC_W] <= acc_sum[c];
`endif
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_neuron_array.sv
// Randomised and directed checks of bin_neuron_array against a vector-level model.
module tb_bin_neuron_array;

  localparam int IN_W  = 8;
  localparam int CH    = 2;
  localparam int ACC_W = 24;
  localparam int LEN_W = 16;
  localparam int SAT_W = 6;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic [IN_W-1:0]      act_in = '0;
  logic [CH*IN_W-1:0]   wgt_in = '0;
  logic [LEN_W-1:0]     in_length = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready, s_in_ready;
  logic                 thr_wr_en = 1'b0;
  logic [0:0]           thr_wr_ch = '0;
  logic [ACC_W-1:0]     thr_wr_data = '0;
  logic [CH-1:0]        out_bits, s_out_bits;
  logic                 out_valid, s_out_valid;
  logic                 out_ready = 1'b0;
`ifdef NEURON_ARRAY_SUM_OUT_EN
  logic [CH*ACC_W-1:0]  out_sum;
  logic [CH*SAT_W-1:0]  s_out_sum;
  logic [CH*SAT_W-1:0]  cap_ssum;
  logic [CH*ACC_W-1:0]  cap_sum;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [IN_W-1:0]      v_act[$];
  logic [CH*IN_W-1:0]   v_wgt[$];
  longint               m_thr[CH];
  logic [CH-1:0]        cap_bits, cap_sbits;

  always #5 sys_clk = ~sys_clk;

  bin_neuron_array #(.IN_W(IN_W), .CH(CH), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .act_in(act_in), .wgt_in(wgt_in),
    .in_length(in_length), .in_valid(in_valid), .in_ready(in_ready),
    .thr_wr_en(thr_wr_en), .thr_wr_ch(thr_wr_ch), .thr_wr_data(thr_wr_data),
    .out_bits(out_bits), .out_valid(out_valid), .out_ready(out_ready)
`ifdef NEURON_ARRAY_SUM_OUT_EN
    , .out_sum(out_sum)
`endif
  );

  bin_neuron_array #(.IN_W(IN_W), .CH(CH), .ACC_W(SAT_W), .LEN_W(LEN_W)) u_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .act_in(act_in), .wgt_in(wgt_in),
    .in_length(in_length), .in_valid(in_valid), .in_ready(s_in_ready),
    .thr_wr_en(thr_wr_en), .thr_wr_ch(thr_wr_ch), .thr_wr_data(thr_wr_data[SAT_W-1:0]),
    .out_bits(s_out_bits), .out_valid(s_out_valid), .out_ready(out_ready)
`ifdef NEURON_ARRAY_SUM_OUT_EN
    , .out_sum(s_out_sum)
`endif
  );

  // Saturating bipolar dot product of the queued vector for one channel.
  function automatic longint ref_sum(input int c, input int accw);
    longint s, hi, lo;
    logic [IN_W-1:0] w;
    s  = 0;
    hi = (longint'(1) <<< (accw - 1)) - 1;
    lo = -hi - 1;
    for (int b = 0; b < v_act.size(); b++) begin
      w = v_wgt[b][c*IN_W +: IN_W];
      s = s + longint'(2 * $countones(~(v_act[b] ^ w)) - IN_W);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
    end
    return s;
  endfunction

  function automatic logic [CH-1:0] exp_bits();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (ref_sum(c, ACC_W) >= m_thr[c]);
    return r;
  endfunction

  task automatic wait_dp();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic write_thr(input int c, input longint val);
    thr_wr_en   = 1'b1;
    thr_wr_ch   = c[0:0];
    thr_wr_data = ACC_W'(val);
    m_thr[c]    = val;
    wait_dp();
    thr_wr_en   = 1'b0;
  endtask

  task automatic drive_beat(input logic [IN_W-1:0] a, input logic [CH*IN_W-1:0] w,
                            input logic [LEN_W-1:0] len);
    int guard;
    act_in = a; wgt_in = w; in_length = len; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      wait_dp();
      guard++;
    end
    nvec++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
    end
    v_act.push_back(a);
    v_wgt.push_back(w);
    wait_dp();
  endtask

  task automatic get_result();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (!out_valid && guard < 50) begin
      wait_dp();
      guard++;
    end
    nvec++;
    if (!out_valid) begin
      nerr++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    cap_bits  = out_bits;
    cap_sbits = s_out_bits;
`ifdef NEURON_ARRAY_SUM_OUT_EN
    cap_sum  = out_sum;
    cap_ssum = s_out_sum;
`endif
    wait_dp();
  endtask

  task automatic test_reset();
    wait_dp();
    nvec += 3;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (out_bits !== '0) begin nerr++; $display("FAIL rst_out_bits: got %b want 00", out_bits); end
    sys_rst_n = 1'b1;
    wait_dp();
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_sign();
    int cyc;
    out_ready = 1'b1;
    drive_beat(8'hFF, {8'h00, 8'hFF}, 16'd1);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      wait_dp();
      cyc++;
    end
    nvec += 2;
    if (cyc != 3) begin nerr++; $display("FAIL sign_latency: got %0d cycles want 3", cyc); end
    if (out_bits !== 2'b01) begin nerr++; $display("FAIL sign_bits: got %b want 01", out_bits); end
    wait_dp();
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL sign_single_result: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_threshold();
    for (int pass = 0; pass < 2; pass++) begin
      write_thr(0, (pass == 0) ? 32 : 33);
      for (int b = 0; b < 4; b++) drive_beat(8'hF0, {8'h0F, 8'hF0}, 16'd4);
      in_valid = 1'b0;
      get_result();
      nvec++;
      if (cap_bits !== ((pass == 0) ? 2'b01 : 2'b00)) begin
        nerr++;
        $display("FAIL thr_edge_%0d: got %b want %b", pass, cap_bits, (pass == 0) ? 2'b01 : 2'b00);
      end
    end
    write_thr(0, 0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(8'hFF, {8'h00, 8'hFF}, 16'd1);
    drive_beat(8'hFF, {8'h0F, 8'h00}, 16'd1);
    in_valid = 1'b0;
    repeat (3) wait_dp();
    nvec += 3;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid: got %0b want 1", out_valid); end
    if (out_bits !== 2'b01) begin nerr++; $display("FAIL bp_hold_bits: got %b want 01", out_bits); end
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    write_thr(1, 1);
    wait_dp();
    nvec++;
    if (out_bits !== 2'b01) begin nerr++; $display("FAIL bp_stable_bits: got %b want 01", out_bits); end
    get_result();
    nvec++;
    if (cap_bits !== 2'b01) begin nerr++; $display("FAIL bp_first: got %b want 01", cap_bits); end
    get_result();
    nvec++;
    if (cap_bits !== 2'b00) begin nerr++; $display("FAIL bp_second: got %b want 00", cap_bits); end
    repeat (3) wait_dp();
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_no_dup: out_valid=%0b want 0", out_valid); end
    write_thr(1, 0);
  endtask

  task automatic test_zero_length();
    logic [CH-1:0] exp_q[$];
    logic [CH-1:0] e;
    out_ready = 1'b0;
    for (int v = 0; v < 2; v++) begin
      v_act.delete(); v_wgt.delete();
      drive_beat(IN_W'($urandom), (CH*IN_W)'($urandom), 16'd0);
      exp_q.push_back(exp_bits());
    end
    in_valid = 1'b0;
    for (int v = 0; v < 2; v++) begin
      get_result();
      e = exp_q.pop_front();
      nvec++;
      if (cap_bits !== e) begin nerr++; $display("FAIL zero_len_%0d: got %b want %b", v, cap_bits, e); end
    end
  endtask

  task automatic test_reset_mid();
    write_thr(0, 20);
    write_thr(1, -40);
    out_ready = 1'b0;
    drive_beat(8'h00, {8'h00, 8'h00}, 16'd1);
    drive_beat(8'hFF, {8'hFF, 8'h00}, 16'd4);
    drive_beat(8'hFF, {8'hFF, 8'h00}, 16'd4);
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL rmid_pending: out_valid=%0b want 1", out_valid); end
    sys_rst_n = 1'b0;
    #1;
    nvec += 3;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
    if (out_bits !== '0) begin nerr++; $display("FAIL rmid_bits: got %b want 00", out_bits); end
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_ready: got %0b want 0", in_ready); end
`ifdef NEURON_ARRAY_SUM_OUT_EN
    nvec++;
    if (out_sum !== '0) begin nerr++; $display("FAIL rmid_sum: got %h want 0", out_sum); end
`endif
    wait_dp();
    sys_rst_n = 1'b1;
    m_thr[0] = 0; m_thr[1] = 0;
    wait_dp();
    write_thr(0, 10);
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) drive_beat(8'hFF, {8'h00, 8'hFC}, 16'd4);
    in_valid = 1'b0;
    get_result();
    nvec++;
    if (cap_bits !== 2'b01) begin nerr++; $display("FAIL rmid_fresh: got %b want 01", cap_bits); end
    write_thr(0, 0);
  endtask

  task automatic test_saturation();
    write_thr(0, 31);
    write_thr(1, -32);
    for (int b = 0; b < 8; b++) drive_beat(8'hFF, {8'h00, 8'hFF}, 16'd8);
    in_valid = 1'b0;
    get_result();
    nvec += 2;
    if (cap_bits !== 2'b01) begin nerr++; $display("FAIL sat_wide_bits: got %b want 01", cap_bits); end
    if (cap_sbits !== 2'b11) begin nerr++; $display("FAIL sat_narrow_bits: got %b want 11", cap_sbits); end
`ifdef NEURON_ARRAY_SUM_OUT_EN
    nvec += 2;
    if (cap_ssum !== {6'b100000, 6'b011111}) begin
      nerr++; $display("FAIL sat_narrow_sum: got %h want 81f", cap_ssum);
    end
    if (cap_sum !== {ACC_W'(-64), ACC_W'(64)}) begin
      nerr++; $display("FAIL sat_wide_sum: got %h want ffffc0000040", cap_sum);
    end
`endif
    write_thr(0, 0);
    write_thr(1, 0);
  endtask

  task automatic test_random();
    localparam int NV = 30;
    logic [CH-1:0] exp_q[$];
    for (int c = 0; c < CH; c++) write_thr(c, longint'($urandom_range(40)) - 20);
    fork
      begin
        int len, nb;
        for (int v = 0; v < NV; v++) begin
          len = $urandom_range(5);
          nb  = (len == 0) ? 1 : len;
          v_act.delete(); v_wgt.delete();
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(3) == 0) begin
              in_valid = 1'b0;
              wait_dp();
            end
            drive_beat(IN_W'($urandom), (CH*IN_W)'($urandom),
                       (b == 0) ? LEN_W'(len) : LEN_W'($urandom));
          end
          exp_q.push_back(exp_bits());
        end
        in_valid = 1'b0;
      end
      begin
        int got, guard;
        logic [CH-1:0] e;
        got = 0; guard = 0;
        while (got < NV && guard < 3000) begin
          @(negedge sys_clk);
          out_ready = ($urandom_range(2) != 0);
          if (out_valid && out_ready) begin
            nvec++;
            if (exp_q.size() == 0) begin
              nerr++; $display("FAIL rand_extra: got %b want none", out_bits);
            end else begin
              e = exp_q.pop_front();
              if (out_bits !== e) begin
                nerr++; $display("FAIL rand_vec_%0d: got %b want %b", got, out_bits, e);
              end
            end
            got++;
          end
          guard++;
        end
        out_ready = 1'b1;
        nvec++;
        if (got != NV) begin nerr++; $display("FAIL rand_count: got %0d want %0d", got, NV); end
      end
    join
  endtask

  initial begin
    m_thr[0] = 0; m_thr[1] = 0;
    test_reset();
    test_sign();
    test_threshold();
    test_backpressure();
    test_zero_length();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bin_neuron_array.md
# bin_neuron_array

Parametrised array of binarised (XNOR-popcount) neurons. Each accepted beat carries one IN_W-bit activation slice shared by CH neurons and a private IN_W-bit weight slice per neuron. The block accumulates bipolar dot products over a programmable vector length, compares each sum against a per-channel signed threshold register, and emits a CH-bit activation word under a valid/ready handshake. It sits between the activation/weight fetch logic and the next layer's input buffer, and is the multi-channel, back-pressured successor of the single binary neuron.

## Interface
- IN_W, 64, activation/weight bits per beat per channel
- CH, 8, number of parallel neurons
- ACC_W, 24, signed accumulator and threshold width
- LEN_W, 16, vector-length width (beats)
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset; one clock; asynchronous, active-low
- act_in  in  IN_W  activation slice, shared by all channels
- wgt_in  in  CH*IN_W  weight slices; channel c = bits [c*IN_W +: IN_W]
- in_length  in  LEN_W  beats per vector; sampled on the first beat of each vector
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- thr_wr_en  in  1  threshold write strobe
- thr_wr_ch  in  $clog2(CH)  channel to write
- thr_wr_data  in  ACC_W  signed threshold
- out_bits  out  CH  bit c = 1 iff sum_c >= thr_c
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready

## Operation
- Pipeline: S1 registers XNOR(act, wgt_c). S2 registers popcount p_c via popcount_tree. S3 accumulates and, on the last beat, compares and loads the output register.
- Per-beat contribution is bipolar: 2*p_c - IN_W, range -IN_W..+IN_W, sign-extended to ACC_W.
- Beat counter counts accepted beats. A beat is last when count+1 >= length. in_length = 0 is treated as 1. The counter and accumulators restart from 0 on the beat after a last beat.
- Accumulator saturates at the signed ACC_W limits and never wraps.
- Compare is signed: out_bits[c] = (sum_c + contribution_c >= thr_c) at the last beat.
- Threshold registers reset to 0. A write in cycle t is used by any compare in cycle t+1 or later, including a vector in flight. Writes are always accepted, regardless of stall.
- Stall = out_valid && !out_ready. While stalled, S1–S3 hold their contents.
- in_ready = !stall.
- out_valid and out_bits hold until the handshake completes. A new result may load in the same cycle as the handshake, so back-to-back results are possible.

## Timing
- Reset values: in_ready 0 while in reset and 1 after, out_valid 0, out_bits 0. All pipeline valids, accumulators, the counter and the thresholds are 0.
- Latency: out_valid rises 3 cycles after the last beat is accepted, when not stalled.
- Throughput: one beat per cycle. Consecutive vectors may be back-to-back with no gap.
- in_valid gaps are allowed mid-vector. Bubbles do not advance the counter or the accumulators.
- Reset mid-vector discards all partial sums and the pending result. The first vector after reset is computed from fresh state.

## Configuration
- NEURON_ARRAY_SUM_OUT_EN defined:
  - Adds output port out_sum, CH*ACC_W bits: the saturated final sum per channel.
  - out_sum is registered with out_bits, is valid under the same handshake, and resets to 0.
- Undefined: port and registers are absent; out_bits behaviour is identical.

## Structure
- Shared package bin_neuron_pkg holds:
  - default IN_W/CH/ACC_W/LEN_W localparams
  - a bipolar-conversion function (pop, width → signed contribution)
  - a signed saturating-add function
- One sub-module: popcount_tree, combinational, parameterised on IN_W, output $clog2(IN_W+1) bits. Instantiated once per channel.

## Test plan
All scenarios use IN_W=8, CH=2, ACC_W=24 unless noted.
- Sign check: act 8'hFF, ch0 wgt 8'hFF, ch1 wgt 8'h00, len 1, thr 0 → sums +8 and -8, out_bits 2'b01, out_valid exactly 3 cycles after acceptance.
- Threshold edge: len 4, act=ch0 wgt=8'hF0 for 4 beats gives sum +32. thr0=32 → bit0=1. Rewrite thr0=33 and rerun → bit0=0.
- Backpressure: two len-1 vectors back-to-back with out_ready low → first result held stable and in_ready drops. Raising out_ready delivers both results in order, nothing lost or duplicated.
- Zero length: in_length 0 → behaves identically to in_length 1.
- Reset mid-vector: assert sys_rst_n low after 2 of 4 beats → all outputs 0 immediately. A following full vector (sum +16) yields the correct bits with no stale contribution.
- Saturation (ACC_W=6): len 8, all beats fully matching → sum clamps to +31, no wrap. With thr +31 → bit=1. With NEURON_ARRAY_SUM_OUT_EN defined, out_sum reads 31.
